// File: rtl/sipm_hit_collector_if.sv
// -----------------------------------------------------------------------------
// sipm_hit_collector_if
//   Valid/ready event stream from one SiPM hit collector to the DAQ
//   aggregation logic.
//
//   event_data  : {seq[5:0], height[1:0], timestamp}, head of the event FIFO
//   event_valid : an event is presented on event_data
//   event_ready : consumer takes event_data on a clock edge where both are high
//
//   master : the collector (drives data/valid, samples ready)
//   slave  : the consumer  (samples data/valid, drives ready)
// -----------------------------------------------------------------------------
interface sipm_hit_collector_if #(
  parameter int TIMESTAMP_LEN = 40
);
  logic [TIMESTAMP_LEN+7:0] event_data;
  logic                     event_valid;
  logic                     event_ready;

  modport master (output event_data, output event_valid, input event_ready);
  modport slave  (input event_data, input event_valid, output event_ready);
endinterface

// File: rtl/sipm_hit_collector.sv
// -----------------------------------------------------------------------------
// sipm_hit_collector
//   Consumer side of a single-SiPM reader. When the reader reports a hit
//   (non-zero height) the timestamp and height are captured together with a
//   6-bit sequence number, pushed into a first-word-fall-through FIFO, and the
//   reader is re-armed by pulsing clear_latches for CLEAR_CYCLES cycles.
//   A one-cycle holdoff follows each clear so the reader's post-clear values
//   settle before hits are qualified again.
//
// Ports
//   clk                  system clock, all logic on posedge
//   rst_n                asynchronous active-low reset
//   enable               1 = accept hits, 0 = ignore hits
//   timestamp_input      timestamp from the reader
//   signal_height_input  0 = no hit, 1..3 = comparator level
//   clear_latches        registered re-arm strobe to the reader
//   evt                  event stream (master side of sipm_hit_collector_if)
//   fifo_count           current FIFO occupancy, 0..FIFO_DEPTH
//   drop_count           hits lost because the FIFO was full, saturating
// -----------------------------------------------------------------------------
module sipm_hit_collector #(
  parameter int TIMESTAMP_LEN = 40,
  parameter int FIFO_DEPTH    = 8,   // power of two, >= 2
  parameter int CLEAR_CYCLES  = 2    // >= 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [TIMESTAMP_LEN-1:0]      timestamp_input,
  input  logic [1:0]                    signal_height_input,
  output logic                          clear_latches,
  sipm_hit_collector_if.master          evt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES + 1) : 1;
  localparam int WW = TIMESTAMP_LEN + 8;

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CLEAR_C = CW'(CLEAR_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_HOLDOFF
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_clr_cnt;
  logic            r_clear;
  logic [5:0]      r_seq;
  logic [15:0]     r_drop;

  logic [WW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic            w_hit;
  logic            w_full;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic [WW-1:0]   w_word;

  // Hits are only qualified in IDLE; during CLEAR/HOLDOFF the reader is
  // being reset and its outputs are not meaningful.
  assign w_hit   = (r_state == S_IDLE) && enable && (signal_height_input != 2'd0);
  assign w_full  = (r_count == DEPTH_C);
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && evt.event_ready;
  // A full FIFO still takes the hit when the head leaves on the same edge.
  assign w_push  = w_hit && (!w_full || w_pop);
  assign w_word  = {r_seq, signal_height_input, timestamp_input};

  // ---------------------------------------------------------------------------
  // Capture / re-arm sequencer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Reader is held cleared during reset and CLEAR_CYCLES after release.
      r_state   <= S_CLEAR;
      r_clr_cnt <= CLEAR_C;
      r_clear   <= 1'b1;
      r_seq     <= '0;
      r_drop    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            // seq advances on pushed and dropped hits alike, so gaps in the
            // downstream sequence reveal drops.
            r_seq <= r_seq + 6'd1;
            if (!w_push && (r_drop != 16'hFFFF)) begin
              r_drop <= r_drop + 16'd1;
            end
            r_state   <= S_CLEAR;
            r_clr_cnt <= CLEAR_C;
            r_clear   <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_clr_cnt == CW'(1)) begin
            r_state <= S_HOLDOFF;
            r_clear <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt - CW'(1);
          end
        end
        S_HOLDOFF: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_CLEAR;
          r_clr_cnt <= CLEAR_C;
          r_clear   <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; only pointers/count are reset, and
  // the output mux below hides stale contents while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // When full, r_wr_ptr == r_rd_ptr; a simultaneous push overwrites the slot
  // whose old contents are being popped on that same edge, preserving order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    evt.event_data = '0;
    if (w_valid) begin
      evt.event_data = r_mem[r_rd_ptr];
    end
  end

  assign evt.event_valid = w_valid;
  assign clear_latches   = r_clear;
  assign fifo_count      = r_count;
  assign drop_count      = r_drop;

endmodule

// File: doc/sipm_hit_collector.md
Name: sipm_hit_collector

Overview:
- Consumer side of the single-SiPM reader interface.
- Samples the reader's timestamp and 2-bit signal height when a hit is reported, and drives the reader's clear_latches to re-arm it.
- Buffers hits in a small first-word-fall-through FIFO and presents them as tagged event words on a valid/ready stream toward the DAQ aggregation logic.
- One instance per SiPM channel.

Parameters:
- TIMESTAMP_LEN, 40: width of timestamp_input and of the timestamp field in event_data.
- FIFO_DEPTH, 8: number of event entries, power of two, minimum 2.
- CLEAR_CYCLES, 2: number of consecutive cycles clear_latches is held high per re-arm, minimum 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = accept hits; 0 = ignore hits.
- timestamp_input  input  TIMESTAMP_LEN  timestamp from reader.
- signal_height_input  input  2  height from reader; 0 = no hit, 1..3 = comparator level.
- clear_latches  output  1  re-arm/clear strobe to reader, registered.
- event_data  output  TIMESTAMP_LEN+8  {seq[5:0], height[1:0], timestamp}; head of FIFO.
- event_valid  output  1  FIFO not empty.
- event_ready  input  1  downstream accepts event_data when high with event_valid.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- drop_count  output  16  hits lost to FIFO full, saturating.

Behaviour:
Reset (rst_n low, asynchronous):
- clear_latches=1, event_valid=0, event_data=0, fifo_count=0, drop_count=0, seq=0.
- State = CLEAR with clear counter loaded to CLEAR_CYCLES, so the reader is cleared during reset and for CLEAR_CYCLES cycles after release.

FSM states:
- IDLE:
  - clear_latches=0.
  - On posedge with enable=1 and signal_height_input!=0: capture {seq, height, timestamp} and write to FIFO at that same edge if a slot is available; otherwise increment drop_count (saturating at 16'hFFFF).
  - seq increments modulo 64 on every detected hit, pushed or dropped, so sequence gaps downstream reveal drops.
  - Go to CLEAR.
- CLEAR:
  - clear_latches=1 for exactly CLEAR_CYCLES cycles, starting the cycle after the capture edge; then go to HOLDOFF.
- HOLDOFF:
  - One cycle with clear_latches=0 and inputs ignored; lets the reader's post-clear values (height 0, timestamp all ones) settle. Then go to IDLE.

Input qualification:
- signal_height_input is ignored in every state except IDLE.
- Minimum hit-to-hit spacing is therefore CLEAR_CYCLES+2 cycles.

enable:
- enable=0 in IDLE: remain in IDLE, no capture, seq and drop_count unchanged.
- enable deasserted during CLEAR/HOLDOFF: the sequence completes normally.

FIFO:
- First-word fall-through: event_data is valid in the same cycle event_valid=1.
- First hit into an empty FIFO: capture at edge N, event_valid=1 from cycle N+1.
- Pop occurs on posedge when event_valid & event_ready.
- While event_valid=1 and event_ready=0, event_data holds stable.
- Full FIFO with a pop in the same edge: the push is accepted (slot freed). fifo_count is unchanged and order is preserved.
- Full FIFO with no pop: the hit is dropped, drop_count+1, and the FSM still goes to CLEAR (reader is always re-armed).
- Simultaneous push and pop on a FIFO with count 1: the new entry becomes the head next cycle, and event_valid stays 1.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.

Reset mid-operation:
- Any state returns immediately to CLEAR with clear_latches=1, the FIFO is emptied, and counters are zeroed.

Test Plan:
1. Release reset, enable=1, height=0 -> clear_latches high during reset and for 2 cycles after release, then low; event_valid=0, fifo_count=0.
2. Height=2'b10, ts=40'h00_0000_1234 held for 1 cycle in IDLE, event_ready=0 -> event_data={6'd0,2'b10,40'h0000001234} with event_valid=1 the next cycle; clear_latches high cycles +1..+2; fifo_count=1.
3. Ten hits spaced 4 cycles apart with event_ready=0 -> fifo_count=8, drop_count=2, seq values 0..7 stored; then event_ready=1 -> 8 words drained in order, then event_valid=0.
4. FIFO full, a hit arrives on the same edge as a pop -> hit accepted, fifo_count stays 8, drop_count unchanged.
5. Height=3 held continuously -> captures every 4 cycles (CLEAR_CYCLES=2); no capture during CLEAR/HOLDOFF; seq increments by 1 per capture.
6. enable=0 with height=1 -> no capture and seq unchanged. Assert rst_n=0 mid-CLEAR with 3 entries queued -> fifo_count=0, event_valid=0, clear_latches=1 immediately.
